// File: rtl/exu_pkg.sv
// exu_pkg: shared types for the execute-to-writeback stage.
// Branch class encoding, payload bundle, branch-resolution helper.
package exu_pkg;

  localparam int BR_WIDTH = 3;
  localparam int XLEN     = 32;
  localparam int REGW     = 5;

  typedef enum logic [BR_WIDTH-1:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_JAL  = 3'd5,
    BR_JALR = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
  } exu_wb_payload_t;

  // EQ/NE look at a SUB result, LT/GE at an SLT(U) result.
  function automatic logic br_taken(
    input br_type_e br,
    input logic     zero,
    input logic     lsb
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      (br == BR_EQ):   t = zero;
      (br == BR_NE):   t = ~zero;
      (br == BR_LT):   t = lsb;
      (br == BR_GE):   t = ~lsb;
      (br == BR_JAL),
      (br == BR_JALR): t = 1'b1;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/exu_skid_buf.sv
// exu_skid_buf: 2-entry valid/ready skid buffer, in_ready_o from a flop.
// Ports: flush_i, in_valid_i/in_ready_o/in_data_i, out_valid_o/out_ready_i/out_data_o;
// skid_valid_o/skid_data_o only when EXU_WB_FWD_EN is defined.
module exu_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
`ifdef EXU_WB_FWD_EN
  ,
  output logic             skid_valid_o,
  output logic [WIDTH-1:0] skid_data_o
`endif
);

  // Encoding is {main_valid, skid_valid} so both handshake
  // outputs come straight off state bits.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready_o  = ~state_q[0];
  assign out_valid_o = state_q[1];
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire = out_valid_o & out_ready_i;

`ifdef EXU_WB_FWD_EN
  assign skid_valid_o = state_q[0];
  assign skid_data_o  = skid_q;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = S_FULL;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/exu_wb_stage.sv
// exu_wb_stage: resolves branch/jump from the ALU result, forms wb data
// and redirect, buffers it in a 2-entry skid buffer.
// Ports: in_* (valid/ready + ALU result and metadata), flush,
// out_* (valid/ready + rd/wen/wdata/redirect).
// Macro EXU_WB_FWD_EN adds fwd0_*/fwd1_* bypass outputs.
module exu_wb_stage
  import exu_pkg::*;
#(
  parameter int DWIDTH = XLEN,
  parameter int RWIDTH = REGW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DWIDTH-1:0]   in_alu_out,
  input  logic [DWIDTH-1:0]   in_pc,
  input  logic [DWIDTH-1:0]   in_imm,
  input  logic [RWIDTH-1:0]   in_rd,
  input  logic                in_rd_wen,
  input  logic [BR_WIDTH-1:0] in_br_type,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RWIDTH-1:0]   out_rd,
  output logic                out_wen,
  output logic [DWIDTH-1:0]   out_wdata,
  output logic                out_redirect,
  output logic [DWIDTH-1:0]   out_redirect_pc
`ifdef EXU_WB_FWD_EN
  ,
  output logic                fwd0_valid,
  output logic [RWIDTH-1:0]   fwd0_rd,
  output logic [DWIDTH-1:0]   fwd0_data,
  output logic                fwd1_valid,
  output logic [RWIDTH-1:0]   fwd1_rd,
  output logic [DWIDTH-1:0]   fwd1_data
`endif
);

  localparam int PW = $bits(exu_wb_payload_t);

  br_type_e        br;
  logic            is_jmp;
  logic            taken;
  logic [DWIDTH-1:0] pc_inc;
  logic [DWIDTH-1:0] br_tgt;
  logic [DWIDTH-1:0] jalr_tgt;
  exu_wb_payload_t pl_in;
  exu_wb_payload_t pl_out;

  assign br       = br_type_e'(in_br_type);
  assign is_jmp   = (br == BR_JAL) | (br == BR_JALR);
  assign taken    = br_taken(br, in_alu_out == '0, in_alu_out[0]);
  assign pc_inc   = in_pc + DWIDTH'(4);
  assign br_tgt   = in_pc + in_imm;
  assign jalr_tgt = {in_alu_out[DWIDTH-1:1], 1'b0};

  always_comb begin
    pl_in             = '0;
    pl_in.rd          = in_rd;
    pl_in.wen         = in_rd_wen & (in_rd != '0);
    pl_in.wdata       = is_jmp ? pc_inc : in_alu_out;
    pl_in.redirect    = taken;
    pl_in.redirect_pc = (br == BR_JALR) ? jalr_tgt : br_tgt;
  end

`ifdef EXU_WB_FWD_EN
  logic            skid_valid;
  exu_wb_payload_t skid_pl;
`endif

  exu_skid_buf #(
    .WIDTH (PW)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pl_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pl_out)
`ifdef EXU_WB_FWD_EN
    ,
    .skid_valid_o (skid_valid),
    .skid_data_o  (skid_pl)
`endif
  );

  assign out_rd          = pl_out.rd;
  assign out_wen         = pl_out.wen;
  assign out_wdata       = pl_out.wdata;
  assign out_redirect    = pl_out.redirect;
  assign out_redirect_pc = pl_out.redirect_pc;

`ifdef EXU_WB_FWD_EN
  assign fwd0_valid = out_valid & pl_out.wen;
  assign fwd0_rd    = pl_out.rd;
  assign fwd0_data  = pl_out.wdata;
  assign fwd1_valid = skid_valid & skid_pl.wen;
  assign fwd1_rd    = skid_pl.rd;
  assign fwd1_data  = skid_pl.wdata;
`endif

endmodule

// File: doc/exu_wb_stage.md
Name: exu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the integer ALU in the NPC core.
- Takes the ALU result and decoded instruction metadata, and resolves the branch or jump from the ALU result.
- Forms the writeback data and a redirect request.
- Buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides, so `in_ready` comes directly from a flop.

Parameters:
- DWIDTH, 32: datapath width of the ALU result, PC, immediate and writeback data.
- RWIDTH, 5: register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a valid ALU result
- in_ready  out  1  stage can accept; driven from a flop (equals !skid_valid)
- in_alu_out  in  DWIDTH  ALU result
- in_pc  in  DWIDTH  instruction PC
- in_imm  in  DWIDTH  branch/JAL immediate
- in_rd  in  RWIDTH  destination register index
- in_rd_wen  in  1  destination write enable
- in_br_type  in  3  branch class (see Behaviour)
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_rd  out  RWIDTH  destination register index
- out_wen  out  1  write enable; forced to 0 when out_rd==0
- out_wdata  out  DWIDTH  writeback data
- out_redirect  out  1  control transfer taken
- out_redirect_pc  out  DWIDTH  redirect target

Behaviour:
- Reset (rst_n low, asynchronous):
  - main_valid=0 and skid_valid=0, so out_valid=0 and in_ready=1.
  - All payload registers are cleared to 0, so every payload output reads 0.
- Branch classes (in_br_type):
  - 0 NONE
  - 1 EQ: taken if in_alu_out==0 (ALU performed SUB)
  - 2 NE: taken if in_alu_out!=0
  - 3 LT: taken if in_alu_out[0]==1 (ALU performed SLT or SLTU)
  - 4 GE: taken if in_alu_out[0]==0
  - 5 JAL: always taken
  - 6 JALR: always taken
  - 7 reserved; treated as NONE
- Payload formation (combinational, before capture):
  - wdata = in_pc+4 for JAL/JALR; otherwise wdata = in_alu_out.
  - Redirect target = in_pc+in_imm for EQ/NE/LT/GE/JAL.
  - Redirect target = {in_alu_out[DWIDTH-1:1],1'b0} for JALR.
  - All sums are modulo 2^DWIDTH; wrap-around is silent.
  - wen = in_rd_wen & (in_rd!=0).
- Handshake:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready.
  - Latency: 1 cycle from in_fire to out_valid when the stage is empty.
  - Sustained throughput: 1 per cycle while out_ready stays high.
- Buffer states (main_valid, skid_valid):
  - EMPTY (0,0): on in_fire, the payload goes to main → ONE.
  - ONE (1,0):
    - in_fire & out_fire: main is replaced by the new payload; stays ONE.
    - in_fire & !out_fire: the payload goes to skid → FULL.
    - out_fire only → EMPTY.
  - FULL (1,1): in_ready=0.
    - out_fire: skid moves to main → ONE.
    - Otherwise: hold.
- Ordering: entries always leave in arrival order.
- Output stability: outputs are held stable while out_valid & !out_ready.
- Flush:
  - At the next edge, main_valid and skid_valid are cleared; payload flops keep their values.
  - No input is accepted in the flush cycle.
  - An out_fire in the flush cycle counts as completed.
  - Flush has priority over every other transition.
- Bound: the stage never holds more than 2 entries and never drops an accepted entry except on flush.
- Upstream flush: generated outside this block from out_fire & out_redirect.

Optional Feature:
- Macro: EXU_WB_FWD_EN.
- Defined: adds forwarding outputs for both buffered entries, so decode can bypass results not yet written back.
  - fwd0_valid, fwd0_rd, fwd0_data from main: fwd0_valid = main_valid & main_wen.
  - fwd1_valid, fwd1_rd, fwd1_data from skid, formed the same way.
  - All six are combinational from flops and read 0 during reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package exu_pkg:
  - br_type_e enum and BR_WIDTH=3.
  - exu_wb_payload_t struct: rd, wen, wdata, redirect, redirect_pc.
- Sub-module exu_skid_buf: generic 2-entry valid/ready skid buffer.
  - Parameterized on payload width (WIDTH).
  - Has a flush input.
  - exu_wb_stage instantiates it after combinational payload formation.

Test Plan:
- Reset then single op: rst_n low 2 cycles, then in_alu_out=0x00000007, rd=5, wen=1, br=NONE with out_ready=1.
  → Next cycle: out_valid=1, out_wdata=7, out_rd=5, out_wen=1, out_redirect=0.
- Branch taken: br=EQ, alu_out=0, pc=0x80000010, imm=0xFFFFFFF0.
  → out_redirect=1, out_redirect_pc=0x80000000.
- Branch not taken: br=NE, alu_out=0.
  → out_redirect=0.
- JALR: pc=0x80000100, alu_out=0x80000203, rd=1.
  → out_wdata=0x80000104, out_redirect_pc=0x80000202.
- Backpressure: out_ready=0, send A,B,C back-to-back.
  → A in main, B in skid, in_ready=0 on the cycle after B, C held upstream.
  → Then out_ready=1: outputs A,B,C in order, each exactly once.
- Flush in FULL state: assert flush for 1 cycle with in_valid=1.
  → Next cycle out_valid=0, in_ready=1, the in_valid payload not captured.
  → rd=0 with wen=1 yields out_wen=0.
